// File: rtl/ps2_defs.sv
// Shared PS/2 Set-2 definitions: prefix bytes, event field layout and prefix FSM states.
package ps2_defs;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;
  localparam logic [7:0] ERR_00     = 8'h00;
  localparam logic [7:0] ERR_FF     = 8'hFF;
  localparam logic [7:0] PAUSE_CODE = 8'h77;

  localparam int EV_W        = 10;
  localparam int EV_BRK      = 9;
  localparam int EV_EXT      = 8;
  localparam int EV_CODE_MSB = 7;
  localparam int EV_CODE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_PAUSE  = 3'd4
  } pfx_state_t;

  // 00 and FF are the keyboard's error / buffer-overrun indications.
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == ERR_00) || (b == ERR_FF);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with occupancy count and sticky overflow flag.
module ps2_event_fifo #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 10,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic              ovf_clear,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_pop;
  logic              do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = rd_en && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (ovf_clear) overflow <= 1'b0;
      if (wr_en && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// Folds PS/2 Set-2 E0/F0 prefixes into key events and queues them for the bus side.
// Optional Pause-sequence filter: define PS2_PAUSE_FILTER_EN.
module ps2_key_event_queue
  import ps2_defs::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              rd_en,
  input  logic              ovf_clear,
  output logic [EV_W-1:0]   rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              kbd_err,
  output logic              irq
);

`ifdef PS2_PAUSE_FILTER_EN
  localparam logic [2:0] PAUSE_SKIP_LAST = 3'd6;
  logic [2:0] skip_cnt;
`endif

  pfx_state_t      state;
  logic            ev_brk;
  logic            ev_ext;
  logic [7:0]      ev_code;
  logic            vld_p1;
  logic [EV_W-1:0] ev_data_p1;

  assign ev_brk  = (state == ST_BRK) || (state == ST_EXTBRK);
  assign ev_ext  = (state == ST_EXT) || (state == ST_EXTBRK) || (state == ST_PAUSE);
  assign ev_code = (state == ST_PAUSE) ? PAUSE_CODE : byte_data;

  // Stage p0 -> p1: decode byte against prefix state, register event strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      vld_p1  <= 1'b0;
      kbd_err <= 1'b0;
`ifdef PS2_PAUSE_FILTER_EN
      skip_cnt <= '0;
`endif
    end else begin
      vld_p1 <= 1'b0;
      if (ovf_clear) kbd_err <= 1'b0;
      if (byte_valid) begin
`ifdef PS2_PAUSE_FILTER_EN
        if (state == ST_PAUSE) begin
          if (is_err_byte(byte_data)) begin
            kbd_err <= 1'b1;
            state   <= ST_IDLE;
          end else if (skip_cnt == PAUSE_SKIP_LAST) begin
            vld_p1 <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            skip_cnt <= skip_cnt + 3'd1;
          end
        end else
`endif
        if (is_err_byte(byte_data)) begin
          kbd_err <= 1'b1;
          state   <= ST_IDLE;
        end else if (byte_data == PFX_PAUSE) begin
`ifdef PS2_PAUSE_FILTER_EN
          state    <= (state == ST_IDLE) ? ST_PAUSE : ST_IDLE;
          skip_cnt <= '0;
`else
          state <= ST_IDLE;
`endif
        end else if (byte_data == PFX_EXT) begin
          state <= ev_brk ? ST_EXTBRK : ST_EXT;
        end else if (byte_data == PFX_BRK) begin
          state <= ev_ext ? ST_EXTBRK : ST_BRK;
        end else begin
          vld_p1 <= 1'b1;
          state  <= ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byte_valid) begin
      ev_data_p1[EV_BRK]                  <= ev_brk;
      ev_data_p1[EV_EXT]                  <= ev_ext;
      ev_data_p1[EV_CODE_MSB:EV_CODE_LSB] <= ev_code;
    end
  end

  // Stage p1 -> queue: event written on the following edge
  ps2_event_fifo #(
    .DEPTH  (DEPTH),
    .WIDTH  (EV_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (vld_p1),
    .wr_data   (ev_data_p1),
    .rd_en     (rd_en),
    .ovf_clear (ovf_clear),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  assign irq = ~empty;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Randomised and directed bench for ps2_key_event_queue against a queue-based key model.
module tb_ps2_key_event_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          rd_en = 1'b0;
  logic          ovf_clear = 1'b0;
  logic [9:0]    rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          kbd_err;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  ps2_key_event_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .rd_en      (rd_en),
    .ovf_clear  (ovf_clear),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .kbd_err    (kbd_err),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: prefix flags seen so far, a one-cycle pending event, and the queue.
  logic [9:0] mq[$];
  bit         m_brk, m_ext;
  int         m_skip;
  bit         pend_vld;
  logic [9:0] pend_data;
  bit         m_ovf, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_brk = 0; m_ext = 0; m_skip = -1;
    pend_vld = 0; pend_data = '0;
    m_ovf = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit bv, input logic [7:0] bd, input bit rd, input bit clr);
    bit pop;
    bit drop;
    pop  = rd && (mq.size() != 0);
    drop = 0;
    if (pop) void'(mq.pop_front());
    if (pend_vld) begin
      if (mq.size() < DEPTH) mq.push_back(pend_data);
      else drop = 1;
    end
    if (clr) begin m_ovf = 0; m_err = 0; end
    if (drop) m_ovf = 1;
    pend_vld = 0;
    if (bv) begin
      if (m_skip >= 0) begin
        if (bd == 8'h00 || bd == 8'hFF) begin m_err = 1; m_skip = -1; end
        else if (m_skip == 6) begin
          pend_vld = 1; pend_data = 10'h177; m_skip = -1;
        end else m_skip++;
      end else if (bd == 8'h00 || bd == 8'hFF) begin
        m_err = 1; m_brk = 0; m_ext = 0;
      end else if (bd == 8'hE1) begin
`ifdef PS2_PAUSE_FILTER_EN
        if (!m_brk && !m_ext) m_skip = 0;
`endif
        m_brk = 0; m_ext = 0;
      end else if (bd == 8'hE0) m_ext = 1;
      else if (bd == 8'hF0) m_brk = 1;
      else begin
        pend_vld = 1; pend_data = {m_brk, m_ext, bd};
        m_brk = 0; m_ext = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [9:0] exp_head;
    exp_head = (mq.size() != 0) ? mq[0] : 10'h000;
    chk("empty",    32'(empty),    32'(mq.size() == 0));
    chk("irq",      32'(irq),      32'(mq.size() != 0));
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("count",    32'(count),    32'(mq.size()));
    chk("rd_data",  32'(rd_data),  32'(exp_head));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("kbd_err",  32'(kbd_err),  32'(m_err));
  endtask

  task automatic step(input bit bv, input logic [7:0] bd, input bit rd, input bit clr);
    byte_valid = bv; byte_data = bd; rd_en = rd; ovf_clear = clr;
    @(posedge clk);
    model_edge(bv, bd, rd, clr);
    #1;
    compare_all();
    byte_valid = 0; byte_data = 8'h00; rd_en = 0; ovf_clear = 0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (!empty && guard < 4 * DEPTH) begin
      step(0, 8'h00, 1, 0);
      guard++;
    end
    chk("drain_bound", 32'(empty), 32'd1);
  endtask

  logic [7:0] codes [9];
  logic [7:0] pause_seq [8];

  initial begin
    model_reset();
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    // Single make code: irq two edges after byte_valid.
    send(8'h1C);
    chk("irq_n", 32'(irq), 32'd0);
    idle(1);
    chk("irq_n1", 32'(irq), 32'd1);
    chk("ev_1c", 32'(rd_data), 32'h01C);
    step(0, 8'h00, 1, 0);
    chk("pop_empty", 32'(empty), 32'd1);
    chk("pop_irq", 32'(irq), 32'd0);

    // Extended break.
    send(8'hE0); send(8'hF0); send(8'h75); idle(1);
    chk("ev_375", 32'(rd_data), 32'h375);
    chk("cnt_375", 32'(count), 32'd1);
    drain();

    // Overflow with nine back-to-back make codes.
    for (int i = 0; i < 9; i++) send(codes[i]);
    idle(1);
    chk("ovf_cnt", 32'(count), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", 32'(rd_data), 32'({2'b00, codes[i]}));
      step(0, 8'h00, 1, 0);
    end
    step(0, 8'h00, 0, 1);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Write and pop on the same edge while full.
    for (int i = 0; i < 8; i++) send(codes[i]);
    idle(1);
    send(codes[8]);
    step(0, 8'h00, 1, 0);
    chk("wp_cnt", 32'(count), 32'd8);
    chk("wp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) step(0, 8'h00, 1, 0);
    chk("wp_tail", 32'(rd_data), 32'({2'b00, codes[8]}));
    drain();

    // Reset mid-sequence discards the pending break prefix.
    send(8'hF0);
    do_reset();
    send(8'h1C); idle(1);
    chk("rst_mid", 32'(rd_data), 32'h01C);
    drain();

    // Keyboard error byte, then clear.
    send(8'hFF);
    chk("kerr_set", 32'(kbd_err), 32'd1);
    step(0, 8'h00, 0, 1);
    chk("kerr_clr", 32'(kbd_err), 32'd0);

    // Pause sequence.
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    idle(1);
`ifdef PS2_PAUSE_FILTER_EN
    chk("pause_cnt", 32'(count), 32'd1);
    chk("pause_ev", 32'(rd_data), 32'h177);
`else
    chk("pause_cnt", 32'(count), 32'd4);
    chk("pause_ev0", 32'(rd_data), 32'h014);
`endif
    drain();

    // Random traffic weighted toward prefixes and error bytes.
    for (int i = 0; i < 3000; i++) begin
      bit         bv, rd, clr;
      logic [7:0] b;
      int         sel;
      bv  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 30);
      clr = ($urandom_range(0, 99) < 4);
      sel = $urandom_range(0, 19);
      case (sel)
        0, 1, 2: b = 8'hE0;
        3, 4, 5: b = 8'hF0;
        6:       b = 8'hE1;
        7:       b = 8'h00;
        8:       b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      step(bv, b, rd, clr);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
